aes_ctr_sequencer: RTL
======================

Name: aes_ctr_sequencer

Overview:
- Sits directly downstream of the Wishbone AES-CTR register front end.
- Takes the 1024-bit plaintext, 256-bit key and 128-bit IV latched by the front end, plus its enable, and drives them through a single-block AES-256 cipher core one 128-bit block at a time.
- Generates counter blocks IV+i and XORs each keystream block with the matching plaintext slice.
- Presents the 1024-bit encrypted result back to the front end for readback.

Parameters:
- NUM_BLOCKS, 8, number of 128-bit blocks per message; the plaintext width is NUM_BLOCKS*BLOCK_W.
- BLOCK_W, 128, AES block width. Fixed; not intended to be overridden.
- KEY_W, 256, AES key width.
- TIMEOUT_CYC, 1024, maximum cycles to wait for aes_done_i before the block aborts with an error.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- ctrenable_i  in  1  start request from the front end; level or pulse.
- plaintext_in  in  1024  message; block i is bits [128i+127:128i].
- key  in  256  AES-256 key.
- iv  in  128  initial counter block.
- aes_start_o  out  1  one-cycle start pulse to the cipher core.
- aes_block_o  out  128  counter block presented to the core.
- aes_key_o  out  256  key presented to the core.
- aes_done_i  in  1  core result valid; one-cycle pulse.
- aes_result_i  in  128  core output, i.e. the keystream block.
- encryptedtext  out  1024  ciphertext; block i is bits [128i+127:128i].
- busy_o  out  1  a message is in progress.
- done_o  out  1  one-cycle pulse when all blocks are complete.
- error_o  out  1  sticky flag: the core timed out.

Behaviour:
- Reset (synchronous, wb_rst_i high at a clock edge):
  - All outputs go to 0: encryptedtext, aes_start_o, aes_block_o, aes_key_o, busy_o, done_o, error_o.
  - State goes to IDLE; internal snapshot, block index and timeout counter are cleared.
  - Reset mid-message aborts the message immediately. Any late aes_done_i is ignored because the state is IDLE.
- Start:
  - In IDLE, ctrenable_i high at an edge snapshots plaintext_in, key and iv into internal registers.
  - The same edge clears encryptedtext and error_o, sets busy_o, sets index to 0 and moves to ISSUE.
  - After this edge the inputs may change without effect.
  - ctrenable_i is ignored in every state other than IDLE. A level-held enable does not retrigger until the FSM has returned to IDLE.
  - Because of that, ctrenable_i still high in the cycle after done_o starts a new message.
- FSM:
  - IDLE: waits for ctrenable_i as described under Start.
  - ISSUE (1 cycle):
    - aes_start_o = 1.
    - aes_block_o = iv_snap + index, 128-bit addition wrapping modulo 2^128.
    - aes_key_o = key_snap.
    - Clears the timeout counter. Next state is WAIT.
  - WAIT:
    - aes_block_o and aes_key_o are held stable; aes_start_o = 0.
    - On aes_done_i: encryptedtext[index] <= pt_snap[index] XOR aes_result_i.
      - If index == NUM_BLOCKS-1, go to DONE.
      - Otherwise increment index and return to ISSUE.
    - If the timeout counter reaches TIMEOUT_CYC-1 without aes_done_i: set error_o, clear busy_o, return to IDLE. Partial ciphertext is retained; done_o is not pulsed.
  - DONE (1 cycle): done_o = 1, busy_o = 0, next state is IDLE.
- aes_done_i is sampled only in WAIT. A done pulse in IDLE, ISSUE or DONE is ignored, including one coincident with aes_start_o.
- Latency: for a core latency of L cycles (aes_done_i high L cycles after aes_start_o, L >= 1), with ctrenable_i sampled at edge 0:
  - block i ISSUE occurs at cycle 1+i(L+1);
  - done_o is high at cycle 8L+9 (NUM_BLOCKS=8).
- encryptedtext holds its value until the next start or reset.
- The index counter is clog2(NUM_BLOCKS) bits wide.

Decomposition:
- Package aes_ctr_pkg holds:
  - AES_BLOCK_W=128 and AES_KEY_W=256;
  - the FSM state encoding: IDLE, ISSUE, WAIT, DONE;
  - a 128-bit counter-increment function.
- One natural sub-module, ctr_block_gen: holds iv_snap and index and produces iv+index combinationally.

Test Plan:
- Reset values: hold wb_rst_i for 3 cycles -> all outputs 0 and state IDLE; aes_done_i pulsed during reset -> no change.
- NIST SP800-38A F.5.5 vector with a golden AES-256 model at L=3:
  - stimulus: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block0 6bc1bee22e409f96e93d7e117393172a;
  - response: encryptedtext[127:0] = 601ec313775789a5b7a7f504bbf3d228, done_o at cycle 33, aes_start_o pulses exactly 8 times.
- Counter wrap: iv = all ones -> aes_block_o is ff..ff for block 0, 00..00 for block 1 and 00..06 for block 7.
- Restart and input stability:
  - ctrenable_i re-pulsed during WAIT and plaintext_in changed mid-message -> no restart, and the result matches the original snapshot;
  - ctrenable_i held high -> a second message starts the cycle after done_o.
- Timeout: core never asserts done with TIMEOUT_CYC=16 -> error_o=1 and busy_o=0 sixteen cycles after the first ISSUE; done_o stays 0; the next start clears error_o.
- Reset mid-operation: wb_rst_i asserted during block 4 WAIT -> encryptedtext=0 and IDLE next cycle; the stray aes_done_i that follows is ignored.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
// Shared widths, FSM encoding and counter arithmetic for the AES-CTR sequencer.
// Counter blocks wrap modulo 2^128.
package aes_ctr_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [AES_BLOCK_W-1:0] ctr_add(
    input logic [AES_BLOCK_W-1:0] base,
    input logic [AES_BLOCK_W-1:0] offset
  );
    return base + offset;
  endfunction

endpackage

// File: rtl/ctr_block_gen.sv
// Holds the IV snapshot and block index; presents iv+index combinationally.
// Zero latency from index to counter block; load wins over advance.
module ctr_block_gen
  import aes_ctr_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   load,
  input  logic                   advance,
  input  logic [AES_BLOCK_W-1:0] iv,
  output logic [IDX_W-1:0]       index,
  output logic [AES_BLOCK_W-1:0] ctr_blk
);

  logic [AES_BLOCK_W-1:0] iv_snap;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      iv_snap <= '0;
      index   <= '0;
    end else if (load) begin
      iv_snap <= iv;
      index   <= '0;
    end else if (advance) begin
      index <= index + IDX_W'(1);
    end
  end

  assign ctr_blk = ctr_add(iv_snap, AES_BLOCK_W'(index));

endmodule

// File: rtl/aes_ctr_sequencer.sv
// Drives a snapshotted message through a single-block AES core in CTR mode, one block per request.
// Per block: 1 ISSUE cycle + core latency; start requests are ignored until back in IDLE.
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_W     = AES_BLOCK_W,
  parameter int KEY_W       = AES_KEY_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          ctrenable_i,
  input  logic [NUM_BLOCKS*BLOCK_W-1:0] plaintext_in,
  input  logic [KEY_W-1:0]              key,
  input  logic [BLOCK_W-1:0]            iv,
  output logic                          aes_start_o,
  output logic [BLOCK_W-1:0]            aes_block_o,
  output logic [KEY_W-1:0]              aes_key_o,
  input  logic                          aes_done_i,
  input  logic [BLOCK_W-1:0]            aes_result_i,
  output logic [NUM_BLOCKS*BLOCK_W-1:0] encryptedtext,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam int MSG_W = NUM_BLOCKS * BLOCK_W;
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]         state;
  logic [MSG_W-1:0]   pt_snap;
  logic [KEY_W-1:0]   key_snap;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [IDX_W-1:0]   blk_idx;
  logic [BLOCK_W-1:0] ctr_blk;
  logic               start_msg;
  logic               next_blk;

  assign start_msg = (state == ST_IDLE) && ctrenable_i;
  assign next_blk  = (state == ST_WAIT) && aes_done_i && (blk_idx != IDX_LAST);

  ctr_block_gen #(
    .IDX_W(IDX_W)
  ) u_ctr_block_gen (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .load    (start_msg),
    .advance (next_blk),
    .iv      (iv),
    .index   (blk_idx),
    .ctr_blk (ctr_blk)
  );

  assign aes_start_o = (state == ST_ISSUE);
  assign aes_block_o = ctr_blk;
  assign aes_key_o   = key_snap;
  assign busy_o      = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done_o      = (state == ST_DONE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      pt_snap       <= '0;
      key_snap      <= '0;
      tmo_cnt       <= '0;
      encryptedtext <= '0;
      error_o       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrenable_i) begin
            pt_snap       <= plaintext_in;
            key_snap      <= key;
            encryptedtext <= '0;
            error_o       <= 1'b0;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (aes_done_i) begin
            encryptedtext[int'(blk_idx)*BLOCK_W +: BLOCK_W] <=
              pt_snap[int'(blk_idx)*BLOCK_W +: BLOCK_W] ^ aes_result_i;
            state <= (blk_idx == IDX_LAST) ? ST_DONE : ST_ISSUE;
          end else begin
            // The ISSUE cycle is the first tick of the window, so the abort
            // lands TIMEOUT_CYC cycles after the start pulse.
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt + TMO_W'(1) == TMO_LAST) begin
              error_o <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
